// File: rtl/demux_1x8_seq.sv
// Registered 1-to-8 demultiplexer: addressed (sel) or scan (ptr) lane fill.
// Ports: clk, rst_n, din, in_valid, sel, mode, clear -> dout, lane_valid,
//   ptr, frame_done (+ parity when DEMUX_PARITY_EN is defined).
module demux_1x8_seq #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   din,
   input  logic               in_valid,
   input  logic [2:0]         sel,
   input  logic               mode,
   input  logic               clear,
   output logic [8*WIDTH-1:0] dout,
   output logic [7:0]         lane_valid,
   output logic [2:0]         ptr,
   output logic               frame_done
`ifdef DEMUX_PARITY_EN
   ,
   output logic               parity
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state, state_n;
   logic               mode_q;
   logic [8*WIDTH-1:0] dout_n;
   logic [7:0]         lv_n;
   logic [2:0]         ptr_n;
   logic               fd_n;

   always_comb begin
      dout_n  = dout;
      lv_n    = lane_valid;
      ptr_n   = ptr;
      state_n = state;
      if (clear) begin
         dout_n  = '0;
         lv_n    = '0;
         ptr_n   = '0;
         state_n = IDLE;
      end else if (mode != mode_q) begin
         // first cycle in a new mode restarts the scan and drops the write
         ptr_n   = '0;
         state_n = IDLE;
      end else if (!mode) begin
         if (in_valid) begin
            dout_n[int'(sel)*WIDTH +: WIDTH] = din;
            lv_n[sel] = 1'b1;
         end
      end else begin
         case (state)
            IDLE, FILL: begin
               if (in_valid) begin
                  dout_n[int'(ptr)*WIDTH +: WIDTH] = din;
                  // lane 0 out of IDLE opens a fresh frame
                  if (state == IDLE && ptr == 3'd0)
                     lv_n = 8'h01;
                  else
                     lv_n = lane_valid | (8'h01 << ptr);
                  ptr_n   = ptr + 3'd1;
                  state_n = (ptr == 3'd7) ? DONE : FILL;
               end
            end
            DONE: begin
               if (in_valid) begin
                  dout_n[WIDTH-1:0] = din;
                  lv_n    = 8'h01;
                  ptr_n   = 3'd1;
                  state_n = FILL;
               end else begin
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      fd_n = (lv_n == 8'hFF) && (lane_valid != 8'hFF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         lane_valid <= '0;
         ptr        <= '0;
         frame_done <= 1'b0;
         mode_q     <= 1'b0;
         state      <= IDLE;
      end else begin
         dout       <= dout_n;
         lane_valid <= lv_n;
         ptr        <= ptr_n;
         frame_done <= fd_n;
         mode_q     <= mode;
         state      <= state_n;
      end
   end

`ifdef DEMUX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         parity <= 1'b0;
      else
         parity <= ^dout_n;
   end
`endif

endmodule
